vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Sequences and shares the 2 KB nametable VRAM between two requesters: the PPU render fetch path and the CPU PPUDATA ($2007) access path.
- Applies nametable mirroring to map 14-bit PPU-space addresses onto the 11-bit VRAM address.
- Drives the vram block's enable, rw_select, addr_in and data_in, and returns its data_out to the winning requester.
- Sits between the PPU core and the vram instance.

Parameters:
- MAX_WAIT, 4: cycles a pending CPU request may be denied before it preempts the PPU.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mirror_mode  in  2  0 = horizontal, 1 = vertical, 2 = single-screen A, 3 = single-screen B.
- ppu_req  in  1  PPU read request; one cycle per fetch.
- ppu_addr  in  14  PPU-space address.
- ppu_gnt  out  1  PPU request accepted this cycle.
- ppu_rd_valid  out  1  PPU read data valid.
- ppu_rd_data  out  8  PPU read data.
- cpu_req  in  1  CPU request, held until acked.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  14  CPU-side PPU-space address.
- cpu_wr_data  in  8  CPU write data.
- cpu_ack  out  1  CPU request accepted (1-cycle pulse).
- cpu_rd_valid  out  1  CPU read data valid (1-cycle pulse).
- cpu_rd_data  out  8  CPU read data; held until the next CPU read returns.
- vram_en  out  1  to vram enable.
- vram_rw  out  1  to vram rw_select: 1 = read, 0 = write.
- vram_addr  out  11  to vram addr_in.
- vram_wr_data  out  8  to vram data_in.
- vram_rd_data  in  8  from vram data_out.

Behaviour:
- The vram read data appears the cycle after issue. It is forced to 0 whenever vram_en is low, so vram_en must stay high during the return cycle.
- Arbitration in issue cycle T, combinational from the current requests:
  - If cpu_req and wait_cnt == MAX_WAIT: CPU wins and ppu_gnt = 0.
  - Else if ppu_req: PPU wins.
  - Else if cpu_req: CPU wins.
  - Else: idle.
- Winner access: vram_en = 1 and vram_addr = mirror(addr) in cycle T.
  - PPU: vram_rw = 1, ppu_gnt = 1.
  - CPU: vram_rw = ~cpu_we, cpu_ack = 1; cpu_addr and cpu_wr_data are sampled in T and the write commits at the T clock edge.
- Idle cycle directly following a read issue: vram_en = 1, vram_rw = 1, vram_addr holds the previous address, so no write can occur.
- Other idle cycles: vram_en = 0, vram_rw = 1.
- Return cycle T+1, using a registered in-flight owner {NONE, PPU, CPU}:
  - PPU owner: ppu_rd_valid = 1, ppu_rd_data = vram_rd_data.
  - CPU owner: cpu_rd_valid = 1, cpu_rd_data = vram_rd_data, and the value is latched at the end of T+1 and held afterwards.
  - CPU writes produce no rd_valid.
- Back-to-back issues are allowed every cycle. The return of access T overlaps the issue of T+1.
- Mirroring: vram_addr[9:0] = addr[9:0]. vram_addr[10] is:
  - horizontal: addr[11]
  - vertical: addr[10]
  - single-A: 0
  - single-B: 1
  - addr[13:12] is ignored.
- mirror_mode is sampled combinationally each issue cycle. A change takes effect on the next issue.
- Starvation counter wait_cnt:
  - Increments (saturating at MAX_WAIT) in each cycle where cpu_req = 1 and cpu_ack = 0.
  - Clears on cpu_ack and whenever cpu_req = 0.
- CPU handshake: the requester deasserts cpu_req the cycle after cpu_ack. A still-high cpu_req is treated as a new request.
- Reset, asynchronous, any time:
  - Cleared to 0: in-flight owner = NONE, wait_cnt, cpu_rd_data, vram_en, ppu_gnt, cpu_ack, both rd_valid outputs, vram_addr, vram_wr_data.
  - vram_rw = 1.
  - A read in flight at reset produces no valid pulse afterwards.

Decomposition:
- Shared package vram_pkg:
  - MIR_HORZ = 2'd0, MIR_VERT = 2'd1, MIR_SCR_A = 2'd2, MIR_SCR_B = 2'd3.
  - owner typedef OWN_NONE / OWN_PPU / OWN_CPU.
  - VRAM_AW = 11.
- Sub-module nt_mirror: combinational 14-bit address plus mirror_mode to 11-bit vram address. One instance, placed after the address mux.

Test Plan:
- Vertical mirroring, CPU write addr 14'h2405 data 8'hA5 -> vram_addr 11'h405, vram_rw 0, cpu_ack in T. Then a CPU read of 14'h2C05 -> vram_addr 11'h405, cpu_rd_valid in T+1 with data 8'hA5.
- Horizontal mirroring, PPU read 14'h2805 -> vram_addr 11'h405. Single-B, PPU read 14'h2005 -> vram_addr 11'h405.
- PPU requests every cycle while CPU holds cpu_req (read) from cycle 0, MAX_WAIT = 4:
  - ppu_gnt = 1 for cycles 0-3.
  - Cycle 4: ppu_gnt = 0, cpu_ack = 1.
  - Cycle 5: cpu_rd_valid = 1; ppu_gnt resumes the same cycle.
- Simultaneous ppu_req and cpu_req with wait_cnt = 0 -> PPU granted and CPU waits. With ppu_req low the next cycle -> CPU acked in that cycle.
- Single PPU read followed by idle -> vram_en stays 1 in T+1 with vram_rw = 1, ppu_rd_valid = 1, then vram_en = 0 in T+2.
- Assert rst in the return cycle of a CPU read -> no cpu_rd_valid, cpu_rd_data = 8'h00, all outputs at their reset values until the first request after release.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared definitions for the nametable VRAM arbiter.
//   MIR_*    : mirror_mode encodings
//   owner_t  : in-flight read owner, used in the return cycle
//   VRAM_AW  : physical nametable VRAM address width (2 KB)
package vram_pkg;
    localparam int VRAM_AW = 11;

    localparam logic [1:0] MIR_HORZ  = 2'd0;
    localparam logic [1:0] MIR_VERT  = 2'd1;
    localparam logic [1:0] MIR_SCR_A = 2'd2;
    localparam logic [1:0] MIR_SCR_B = 2'd3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PPU  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;
endpackage

// File: rtl/vram_nt_mirror.sv
// Nametable mirroring: folds a 14-bit PPU-space address onto the 11-bit
// physical VRAM address.
//   addr        in  14  PPU-space address (bits 13:12 ignored)
//   mirror_mode in  2   MIR_HORZ / MIR_VERT / MIR_SCR_A / MIR_SCR_B
//   vram_addr   out 11  physical VRAM address
module nt_mirror
    import vram_pkg::*;
(
    input  logic [13:0]        addr,
    input  logic [1:0]         mirror_mode,
    output logic [VRAM_AW-1:0] vram_addr
);
    logic unused_hi;
    assign unused_hi = ^addr[13:12];

    always_comb begin
        vram_addr = {1'b0, addr[9:0]};
        case (mirror_mode)
            MIR_HORZ:  vram_addr[10] = addr[11];
            MIR_VERT:  vram_addr[10] = addr[10];
            MIR_SCR_A: vram_addr[10] = 1'b0;
            MIR_SCR_B: vram_addr[10] = 1'b1;
            default:   vram_addr[10] = 1'b0;
        endcase
    end
endmodule

// File: rtl/vram_arbiter.sv
// Shares the 2 KB nametable VRAM between the PPU fetch path and the CPU
// PPUDATA path. One access may issue per cycle; read data returns the next
// cycle, overlapping the following issue.
//   mirror_mode                      nametable mirroring select
//   ppu_req/ppu_addr -> ppu_gnt      PPU single-cycle read requests
//   ppu_rd_valid/ppu_rd_data         PPU read return (T+1)
//   cpu_req/we/addr/wr_data -> ack   CPU request, held until acked
//   cpu_rd_valid/cpu_rd_data         CPU read return; data held afterwards
//   vram_en/rw/addr/wr_data          to vram block (rw: 1 = read)
//   vram_rd_data                     from vram block (0 when vram_en low)
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mirror_mode,
    input  logic               ppu_req,
    input  logic [13:0]        ppu_addr,
    output logic               ppu_gnt,
    output logic               ppu_rd_valid,
    output logic [7:0]         ppu_rd_data,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [13:0]        cpu_addr,
    input  logic [7:0]         cpu_wr_data,
    output logic               cpu_ack,
    output logic               cpu_rd_valid,
    output logic [7:0]         cpu_rd_data,
    output logic               vram_en,
    output logic               vram_rw,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wr_data,
    input  logic [7:0]         vram_rd_data
);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0]   wait_cnt;
    owner_t             owner_q, owner_d;
    logic [VRAM_AW-1:0] last_addr_q, mir_addr;
    logic [7:0]         cpu_rd_q;
    logic               cpu_win, ppu_win;
    logic [13:0]        sel_addr;

    // Grants are suppressed while reset is held so every output sits at its
    // reset value regardless of what the requesters are doing.
    always_comb begin
        cpu_win = 1'b0;
        ppu_win = 1'b0;
        if (!rst) begin
            if (cpu_req && wait_cnt == WAIT_MAX) cpu_win = 1'b1;
            else if (ppu_req)                    ppu_win = 1'b1;
            else if (cpu_req)                    cpu_win = 1'b1;
        end
    end

    assign sel_addr = cpu_win ? cpu_addr : ppu_addr;

    nt_mirror u_mirror (
        .addr        (sel_addr),
        .mirror_mode (mirror_mode),
        .vram_addr   (mir_addr)
    );

    always_comb begin
        ppu_gnt      = ppu_win;
        cpu_ack      = cpu_win;
        // Keep the vram enabled through a read's return cycle, otherwise it
        // zeroes its data_out; rw stays 1 there so nothing gets written.
        vram_en      = cpu_win | ppu_win | (owner_q != OWN_NONE);
        vram_rw      = ~(cpu_win & cpu_we);
        vram_addr    = (cpu_win | ppu_win) ? mir_addr : last_addr_q;
        vram_wr_data = (cpu_win & cpu_we) ? cpu_wr_data : 8'h00;

        owner_d = OWN_NONE;
        if (cpu_win && !cpu_we) owner_d = OWN_CPU;
        else if (ppu_win)       owner_d = OWN_PPU;

        ppu_rd_valid = (owner_q == OWN_PPU);
        ppu_rd_data  = ppu_rd_valid ? vram_rd_data : 8'h00;
        cpu_rd_valid = (owner_q == OWN_CPU);
        cpu_rd_data  = cpu_rd_valid ? vram_rd_data : cpu_rd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            wait_cnt    <= '0;
            last_addr_q <= '0;
            cpu_rd_q    <= 8'h00;
        end else begin
            owner_q <= owner_d;
            if (cpu_win | ppu_win) last_addr_q <= mir_addr;
            if (cpu_rd_valid)      cpu_rd_q    <= vram_rd_data;
            if (cpu_req && !cpu_win) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mirror_mode = 2'd0;
    logic        ppu_req = 1'b0;
    logic [13:0] ppu_addr = '0;
    logic        ppu_gnt, ppu_rd_valid;
    logic [7:0]  ppu_rd_data;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [7:0]  cpu_wr_data = '0;
    logic        cpu_ack, cpu_rd_valid;
    logic [7:0]  cpu_rd_data;
    logic        vram_en, vram_rw;
    logic [10:0] vram_addr;
    logic [7:0]  vram_wr_data, vram_rd_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .mirror_mode(mirror_mode),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_gnt(ppu_gnt),
        .ppu_rd_valid(ppu_rd_valid), .ppu_rd_data(ppu_rd_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_ack(cpu_ack),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
        .vram_en(vram_en), .vram_rw(vram_rw), .vram_addr(vram_addr),
        .vram_wr_data(vram_wr_data), .vram_rd_data(vram_rd_data)
    );

    // Behavioural vram block: synchronous, data one cycle after issue,
    // forced to zero while disabled.
    logic       mem_clr = 1'b1;
    logic [7:0] mem [0:2047];
    logic [7:0] rd_q = 8'h00;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'(i * 37 + 5);
        end else if (vram_en) begin
            if (!vram_rw) mem[vram_addr] <= vram_wr_data;
            rd_q <= mem[vram_addr];
        end
    end
    assign vram_rd_data = vram_en ? rd_q : 8'h00;

    // Reference model: expected VRAM contents plus the pending return.
    logic [7:0] refmem [0:2047];
    int         m_wait = 0;
    int         m_ret = 0;          // 0 none, 1 PPU read, 2 CPU read
    logic [7:0] m_ret_data = 8'h00;
    logic [7:0] m_cpu_rd = 8'h00;
    int         m_last = 0;
    bit         last_ack = 1'b0;

    function automatic int ref_mirror(input int mode, input int a);
        int q, t;
        q = (a / 1024) % 4;      // logical nametable 0..3
        case (mode)
            0:       t = q / 2;
            1:       t = q % 2;
            2:       t = 0;
            default: t = 1;
        endcase
        return t * 1024 + a % 1024;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_wait = 0; m_ret = 0; m_ret_data = 8'h00; m_cpu_rd = 8'h00; m_last = 0;
    endtask

    // Called at the negedge: compare every output to the model, then
    // advance across the posedge and update the model.
    task automatic tick();
        bit cw, pw;
        int a;
        cw = cpu_req && (m_wait >= MAX_WAIT || !ppu_req);
        pw = ppu_req && !cw;
        a  = cw ? ref_mirror(int'(mirror_mode), int'(cpu_addr))
                : ref_mirror(int'(mirror_mode), int'(ppu_addr));
        chk("ppu_gnt", 32'(ppu_gnt), 32'(pw));
        chk("cpu_ack", 32'(cpu_ack), 32'(cw));
        chk("vram_en", 32'(vram_en), 32'(cw || pw || m_ret != 0));
        chk("vram_rw", 32'(vram_rw), 32'(!(cw && cpu_we)));
        chk("vram_addr", 32'(vram_addr), (cw || pw) ? 32'(a) : 32'(m_last));
        if (cw && cpu_we) chk("vram_wr_data", 32'(vram_wr_data), 32'(cpu_wr_data));
        chk("ppu_rd_valid", 32'(ppu_rd_valid), 32'(m_ret == 1));
        if (m_ret == 1) chk("ppu_rd_data", 32'(ppu_rd_data), 32'(m_ret_data));
        chk("cpu_rd_valid", 32'(cpu_rd_valid), 32'(m_ret == 2));
        chk("cpu_rd_data", 32'(cpu_rd_data), (m_ret == 2) ? 32'(m_ret_data) : 32'(m_cpu_rd));
        @(posedge clk);
        if (m_ret == 2) m_cpu_rd = m_ret_data;
        m_ret = 0;
        if (cw || pw) m_last = a;
        if (cw && cpu_we) refmem[a] = cpu_wr_data;
        else if (cw) begin m_ret = 2; m_ret_data = refmem[a]; end
        else if (pw) begin m_ret = 1; m_ret_data = refmem[a]; end
        if (cpu_req && !cw) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
        else m_wait = 0;
        last_ack = cw;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) refmem[i] = 8'(i * 37 + 5);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_vram_en", 32'(vram_en), 32'd0);
        chk("rst_vram_rw", 32'(vram_rw), 32'd1);
        chk("rst_cpu_rd_data", 32'(cpu_rd_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk); tick();

        // Vertical: CPU write then CPU read through the other mirror
        mirror_mode = 2'd1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 14'h2405; cpu_wr_data = 8'hA5;
        @(negedge clk);
        chk("v_wr_addr", 32'(vram_addr), 32'h405);
        chk("v_wr_rw", 32'(vram_rw), 32'd0);
        chk("v_wr_ack", 32'(cpu_ack), 32'd1);
        tick();
        cpu_req = 0; @(negedge clk); tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h2C05;
        @(negedge clk);
        chk("v_rd_addr", 32'(vram_addr), 32'h405);
        tick();
        cpu_req = 0;
        @(negedge clk);
        chk("v_rd_valid", 32'(cpu_rd_valid), 32'd1);
        chk("v_rd_data", 32'(cpu_rd_data), 32'hA5);
        tick();

        // Horizontal PPU read, then idle return cycle behaviour
        mirror_mode = 2'd0; ppu_req = 1; ppu_addr = 14'h2805;
        @(negedge clk);
        chk("h_addr", 32'(vram_addr), 32'h405);
        tick();
        ppu_req = 0;
        @(negedge clk);
        chk("ret_en", 32'(vram_en), 32'd1);
        chk("ret_valid", 32'(ppu_rd_valid), 32'd1);
        chk("ret_data", 32'(ppu_rd_data), 32'hA5);
        tick();
        @(negedge clk);
        chk("idle_en", 32'(vram_en), 32'd0);
        tick();

        // Single-screen B
        mirror_mode = 2'd3; ppu_req = 1; ppu_addr = 14'h2005;
        @(negedge clk);
        chk("sb_addr", 32'(vram_addr), 32'h405);
        tick();

        // Starvation: PPU every cycle, CPU read held from cycle 0
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h2000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("starve_ppu_gnt", 32'(ppu_gnt), 32'd1);
            chk("starve_cpu_wait", 32'(cpu_ack), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("preempt_gnt", 32'(ppu_gnt), 32'd0);
        chk("preempt_ack", 32'(cpu_ack), 32'd1);
        tick();
        cpu_req = 0;
        @(negedge clk);
        chk("preempt_rd_valid", 32'(cpu_rd_valid), 32'd1);
        chk("preempt_ppu_resume", 32'(ppu_gnt), 32'd1);
        tick();

        // Simultaneous requests with no backlog: PPU first
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h2405; mirror_mode = 2'd1;
        @(negedge clk);
        chk("sim_ppu", 32'(ppu_gnt), 32'd1);
        chk("sim_cpu_wait", 32'(cpu_ack), 32'd0);
        tick();
        ppu_req = 0;
        @(negedge clk);
        chk("sim_cpu_ack", 32'(cpu_ack), 32'd1);
        tick();
        cpu_req = 0;
        @(negedge clk); tick();

        // Reset during the return cycle of a CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h2805; mirror_mode = 2'd0;
        @(negedge clk); tick();
        cpu_req = 0; rst = 1; model_reset();
        @(negedge clk);
        chk("rr_valid", 32'(cpu_rd_valid), 32'd0);
        chk("rr_data", 32'(cpu_rd_data), 32'd0);
        chk("rr_en", 32'(vram_en), 32'd0);
        chk("rr_addr", 32'(vram_addr), 32'd0);
        tick();
        rst = 0;
        repeat (2) begin @(negedge clk); tick(); end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if (cpu_req && last_ack) cpu_req = 0;
            else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom);
                cpu_addr = 14'($urandom); cpu_wr_data = 8'($urandom);
            end
            ppu_req  = ($urandom_range(0, 3) != 0);
            ppu_addr = 14'($urandom);
            if ($urandom_range(0, 15) == 0) mirror_mode = 2'($urandom);
            @(negedge clk);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
